// File: rtl/ahb_timer_if.sv
// AHB-Lite bus bundle between a bus master (decoder side) and the ahb_timer slave.
interface ahb_timer_if;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;

  modport master (
    output HSEL, HREADY, HADDR, HTRANS, HWRITE, HWDATA,
    input  HRDATA, HREADYOUT
  );

  modport slave (
    input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HWDATA,
    output HRDATA, HREADYOUT
  );
endinterface

// File: rtl/ahb_timer.sv
// Zero-wait-state AHB-Lite down-counter timer with prescaler, one-shot mode and level IRQ.
// Optional COMPARE register and PWM output are built only when AHB_TIMER_PWM_EN is defined.
module ahb_timer #(
  parameter int WIDTH     = 32,
  parameter int PSC_WIDTH = 8
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  ahb_timer_if.slave ahb,
  output logic       timer_irq,
  output logic       pwm_out
);
  localparam logic [2:0] ADDR_LOAD   = 3'd0;
  localparam logic [2:0] ADDR_VALUE  = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;

  logic                 wrPend_q, rdPend_q;
  logic [2:0]           addr_q;
  logic [WIDTH-1:0]     load_q, load_d, value_q, value_d;
  logic                 en_q, en_d, ie_q, ie_d, oneShot_q, oneShot_d;
  logic [PSC_WIDTH-1:0] psc_q, psc_d, prescCnt_q, prescCnt_d;
  logic                 tof_q, tof_d, irq_q;
  logic                 tick, expire, wrLoad, wrValue, wrCtrl, wrStatus, ctrlStop;
  logic [31:0]          rdata;

  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRDATA    = rdata;
  assign timer_irq     = irq_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wrPend_q <= 1'b0;
      rdPend_q <= 1'b0;
      addr_q   <= '0;
    end else if (ahb.HREADY) begin
      wrPend_q <= ahb.HSEL & ahb.HTRANS[1] & ahb.HWRITE;
      rdPend_q <= ahb.HSEL & ahb.HTRANS[1] & ~ahb.HWRITE;
      addr_q   <= ahb.HADDR[4:2];
    end
  end

  assign wrLoad   = wrPend_q && (addr_q == ADDR_LOAD);
  assign wrValue  = wrPend_q && (addr_q == ADDR_VALUE);
  assign wrCtrl   = wrPend_q && (addr_q == ADDR_CTRL);
  assign wrStatus = wrPend_q && (addr_q == ADDR_STATUS);
  assign ctrlStop = wrCtrl && !ahb.HWDATA[0];
  assign tick     = en_q && (prescCnt_q == psc_q);
  assign expire   = tick && (value_q == '0);

  // Hardware counting first, then bus writes override; a TOF set beats a STATUS clear.
  always_comb begin
    load_d     = load_q;
    value_d    = value_q;
    en_d       = en_q;
    ie_d       = ie_q;
    oneShot_d  = oneShot_q;
    psc_d      = psc_q;
    tof_d      = tof_q;
    prescCnt_d = (en_q && !tick) ? prescCnt_q + PSC_WIDTH'(1) : '0;
    if (tick) begin
      if (value_q != '0)   value_d = value_q - WIDTH'(1);
      else if (!oneShot_q) value_d = load_q;
      else                 en_d    = 1'b0;
    end
    if (wrStatus && ahb.HWDATA[0]) tof_d = 1'b0;
    if (expire && !ctrlStop)       tof_d = 1'b1;
    if (wrLoad) load_d = ahb.HWDATA[WIDTH-1:0];
    if (wrValue) begin
      value_d    = ahb.HWDATA[WIDTH-1:0];
      prescCnt_d = '0;
    end
    if (wrCtrl) begin
      en_d      = ahb.HWDATA[0];
      ie_d      = ahb.HWDATA[1];
      oneShot_d = ahb.HWDATA[2];
      psc_d     = ahb.HWDATA[8 +: PSC_WIDTH];
      if (!ahb.HWDATA[0]) begin
        value_d    = value_q;
        prescCnt_d = '0;
      end else if (!en_q || expire) begin
        value_d    = load_q;
        prescCnt_d = '0;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      load_q     <= '0;
      value_q    <= '0;
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      oneShot_q  <= 1'b0;
      psc_q      <= '0;
      prescCnt_q <= '0;
      tof_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      load_q     <= load_d;
      value_q    <= value_d;
      en_q       <= en_d;
      ie_q       <= ie_d;
      oneShot_q  <= oneShot_d;
      psc_q      <= psc_d;
      prescCnt_q <= prescCnt_d;
      tof_q      <= tof_d;
      irq_q      <= tof_q & ie_q;
    end
  end

`ifdef AHB_TIMER_PWM_EN
  localparam logic [2:0] ADDR_COMPARE = 3'd4;

  logic [WIDTH-1:0] compare_q;
  logic             pwm_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      compare_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      if (wrPend_q && (addr_q == ADDR_COMPARE)) compare_q <= ahb.HWDATA[WIDTH-1:0];
      pwm_q <= en_q && (value_q < compare_q);
    end
  end

  assign pwm_out = pwm_q;
`else
  assign pwm_out = 1'b0;
`endif

  // Read data is decoded from the latched address and zero outside a read data phase.
  always_comb begin
    rdata = '0;
    if (rdPend_q) begin
      case (addr_q)
        ADDR_LOAD:   rdata[WIDTH-1:0] = load_q;
        ADDR_VALUE:  rdata[WIDTH-1:0] = value_q;
        ADDR_CTRL: begin
          rdata[0]              = en_q;
          rdata[1]              = ie_q;
          rdata[2]              = oneShot_q;
          rdata[8 +: PSC_WIDTH] = psc_q;
        end
        ADDR_STATUS: rdata[0] = tof_q;
`ifdef AHB_TIMER_PWM_EN
        ADDR_COMPARE: rdata[WIDTH-1:0] = compare_q;
`endif
        default: rdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_timer.sv
// Scoreboard bench for ahb_timer: directed AHB transfers push expected read data, a monitor checks it.
module tb_ahb_timer;
  localparam logic [31:0] A_LOAD    = 32'h00;
  localparam logic [31:0] A_VALUE   = 32'h04;
  localparam logic [31:0] A_CTRL    = 32'h08;
  localparam logic [31:0] A_STATUS  = 32'h0C;
  localparam logic [31:0] A_COMPARE = 32'h10;

  typedef struct {
    logic [31:0] data;
    string       name;
  } expT;

  logic HCLK    = 1'b0;
  logic HRESETn = 1'b0;
  logic timer_irq, pwm_out;

  expT         scoreQ[$];
  int          checks = 0;
  int          errors = 0;
  int          pwmHigh;
  logic        dataPhaseRd = 1'b0;
  logic        pendRd      = 1'b0;
  logic [31:0] pendWdata   = '0;

  ahb_timer_if bus();

  ahb_timer #(.WIDTH(32), .PSC_WIDTH(8)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .ahb       (bus),
    .timer_irq (timer_irq),
    .pwm_out   (pwm_out)
  );

  always #10 HCLK = ~HCLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // One bus cycle: data phase of the previous transfer plus address phase of a new one.
  task automatic applyStimulus(input logic doXfer, input logic isWrite, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expRd, input string name);
    expT e;
    bus.HWDATA  = pendWdata;
    dataPhaseRd = pendRd;
    bus.HSEL    = doXfer;
    bus.HTRANS  = doXfer ? 2'b10 : 2'b00;
    bus.HWRITE  = isWrite;
    bus.HADDR   = addr;
    pendRd      = doXfer && !isWrite;
    pendWdata   = wdata;
    if (doXfer && !isWrite) begin
      e.data = expRd;
      e.name = name;
      scoreQ.push_back(e);
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b1, addr, data, 32'h0, "");
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] expRd, input string name);
    applyStimulus(1'b1, 1'b0, addr, 32'h0, expRd, name);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, "");
  endtask

  always @(negedge HCLK) begin
    expT e;
    if (dataPhaseRd) begin
      if (scoreQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard underflow: got read data 0x%08h expected a queued entry", bus.HRDATA);
      end else begin
        e = scoreQ.pop_front();
        checkOutput(e.name, bus.HRDATA, e.data);
      end
      checkOutput("HREADYOUT in data phase", 32'(bus.HREADYOUT), 32'h1);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got time %0t expected finish before 2000000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.HSEL   = 1'b0;
    bus.HREADY = 1'b1;
    bus.HADDR  = '0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HWDATA = '0;
    #5;
    checkOutput("reset HRDATA", bus.HRDATA, 32'h0);
    checkOutput("reset timer_irq", 32'(timer_irq), 32'h0);
    checkOutput("reset pwm_out", 32'(pwm_out), 32'h0);
    checkOutput("reset HREADYOUT", 32'(bus.HREADYOUT), 32'h1);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    // Periodic mode, LOAD=4, PSC=0, IE
    wr(A_LOAD, 32'd4);
    wr(A_CTRL, 32'h3);
    rd(A_VALUE, 32'd4, "periodic VALUE 4");
    rd(A_VALUE, 32'd3, "periodic VALUE 3");
    rd(A_VALUE, 32'd2, "periodic VALUE 2");
    rd(A_VALUE, 32'd1, "periodic VALUE 1");
    rd(A_VALUE, 32'd0, "periodic VALUE 0");
    rd(A_VALUE, 32'd4, "periodic reload 4");
    checkOutput("irq low in TOF cycle", 32'(timer_irq), 32'h0);
    rd(A_STATUS, 32'h1, "periodic TOF set");
    checkOutput("irq high one cycle after TOF", 32'(timer_irq), 32'h1);

    // STATUS clear racing a hardware TOF set
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, 32'h0, "TOF cleared");
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, 32'h1, "TOF set beats clear");
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, 32'h0, "TOF clear alone");
    checkOutput("irq lags TOF clear", 32'(timer_irq), 32'h1);
    wr(A_CTRL, 32'h0);
    checkOutput("irq low after TOF clear", 32'(timer_irq), 32'h0);
    rd(A_VALUE, 32'd1, "EN clear beats tick");
    rd(A_CTRL, 32'h0, "CTRL stopped");
    idle(1);

    // Bus write priority and zero-wait back-to-back access
    wr(A_LOAD, 32'h200);
    wr(A_CTRL, 32'h1);
    idle(2);
    wr(A_VALUE, 32'h100);
    rd(A_VALUE, 32'h100, "VALUE write beats tick");
    rd(A_VALUE, 32'h0FF, "count resumes after write");
    wr(A_LOAD, 32'h55);
    rd(A_LOAD, 32'h55, "LOAD back-to-back");
    wr(A_CTRL, 32'h0);
    idle(1);

    // Prescaled one-shot, LOAD=2, PSC=3
    wr(A_STATUS, 32'h1);
    wr(A_LOAD, 32'd2);
    wr(A_CTRL, 32'h305);
    idle(11);
    rd(A_STATUS, 32'h0, "oneshot TOF not yet");
    rd(A_STATUS, 32'h1, "oneshot TOF at 12 cycles");
    rd(A_CTRL, 32'h304, "oneshot EN cleared");
    rd(A_VALUE, 32'h0, "oneshot VALUE 0");
    idle(4);
    rd(A_VALUE, 32'h0, "oneshot VALUE held 0");
    checkOutput("irq low with IE off", 32'(timer_irq), 32'h0);

    // One-shot expiry coinciding with a CTRL write re-enabling
    wr(A_STATUS, 32'h1);
    wr(A_CTRL, 32'h5);
    idle(2);
    wr(A_CTRL, 32'h5);
    rd(A_CTRL, 32'h5, "rearm on expiry keeps EN");
    rd(A_VALUE, 32'd1, "rearm on expiry reloads");
    wr(A_CTRL, 32'h0);
    idle(1);

`ifdef AHB_TIMER_PWM_EN
    wr(A_LOAD, 32'd9);
    wr(A_COMPARE, 32'd3);
    wr(A_CTRL, 32'h1);
    idle(3);
    pwmHigh = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (pwm_out) pwmHigh++;
    end
    checkOutput("pwm high cycles in 20", 32'(pwmHigh), 32'd6);
    rd(A_COMPARE, 32'd3, "COMPARE readback");
`else
    wr(A_LOAD, 32'd9);
    wr(A_COMPARE, 32'd3);
    rd(A_COMPARE, 32'h0, "unmapped 0x10 reads 0");
    rd(A_LOAD, 32'd9, "LOAD untouched by 0x10 write");
    wr(A_CTRL, 32'h1);
    idle(3);
    pwmHigh = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (pwm_out) pwmHigh++;
    end
    checkOutput("pwm_out tied low", 32'(pwmHigh), 32'd0);
`endif

    // Asynchronous reset mid-count
    wr(A_CTRL, 32'h3);
    idle(12);
    checkOutput("irq high before reset", 32'(timer_irq), 32'h1);
    #3;
    HRESETn = 1'b0;
    #1;
    checkOutput("async reset timer_irq", 32'(timer_irq), 32'h0);
    checkOutput("async reset pwm_out", 32'(pwm_out), 32'h0);
    checkOutput("async reset HRDATA", bus.HRDATA, 32'h0);
    checkOutput("async reset HREADYOUT", 32'(bus.HREADYOUT), 32'h1);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    rd(A_LOAD, 32'h0, "reset LOAD");
    rd(A_VALUE, 32'h0, "reset VALUE");
    rd(A_CTRL, 32'h0, "reset CTRL");
    rd(A_STATUS, 32'h0, "reset STATUS");
    idle(2);
    checkOutput("irq low after reset", 32'(timer_irq), 32'h0);

    checkOutput("scoreboard drained", 32'(scoreQ.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_timer.md
Name: ahb_timer

Overview:
- Zero-wait-state AHB-Lite slave: programmable down-counter timer with 8-bit prescaler, periodic/one-shot modes and level interrupt.
- Sits on the system bus beside GPIO/UART/SPI, in a free decoder slot.
- Drives the currently unused processor interrupt line IRQ[0].
- Firmware uses it for tick generation and timeouts (e.g. SPI accelerometer polling interval).

Parameters:
- WIDTH, 32, counter/LOAD/VALUE width in bits (1..32); unused upper HRDATA bits read 0.
- PSC_WIDTH, 8, prescaler field width; the tick divides HCLK by (PSC+1).

Ports:
- HCLK  input  1  bus clock (50 MHz)
- HRESETn  input  1  asynchronous active-low reset
- HSEL  input  1  slave select from address decoder
- HREADY  input  1  previous transfer completing
- HADDR  input  32  address; only HADDR[4:2] decoded
- HTRANS  input  2  transfer type; only bit 1 used
- HWRITE  input  1  write transfer
- HWDATA  input  32  write data (data phase)
- HRDATA  output  32  read data
- HREADYOUT  output  1  always 1
- timer_irq  output  1  level interrupt to IRQ[0]
- pwm_out  output  1  PWM output; 0 unless AHB_TIMER_PWM_EN

Behaviour:
- Clock and reset: one clock HCLK. Reset is asynchronous and active-low on HRESETn.
- Reset values: all registers 0, prescaler count 0, HRDATA 0, timer_irq 0, pwm_out 0, HREADYOUT 1.
- Address phase: when HSEL & HREADY & HTRANS[1], register write flag = HWRITE and read flag = !HWRITE, plus HADDR[4:2].
- Data phase:
  - Writes use HWDATA in the data-phase cycle.
  - Reads: HRDATA is combinational from the latched address and current register values.
  - HSIZE ignored; 32-bit accesses only.
  - Unmapped offsets read 0; writes to them are ignored.
- Register map:
  - 0x00 LOAD (RW): reload value.
  - 0x04 VALUE (RW): current count. A write sets the count immediately and clears the prescaler.
  - 0x08 CTRL (RW):
    - bit0 EN.
    - bit1 IE.
    - bit2 ONESHOT.
    - bits[8+PSC_WIDTH-1:8] PSC.
  - 0x0C STATUS: bit0 TOF. Reads return TOF. Writing 1 clears TOF; writing 0 has no effect.
  - 0x10 COMPARE (RW): present only with AHB_TIMER_PWM_EN.
- Prescaler:
  - While EN=1, the prescaler counts 0..PSC and a tick pulses on the cycle it equals PSC, then it wraps to 0.
  - PSC=0 gives a tick every cycle.
  - Prescaler is held at 0 while EN=0.
- Enable edge: a CTRL write changing EN 0->1 loads VALUE<=LOAD and clears the prescaler. The first tick comes PSC+1 cycles later.
- On each tick:
  - VALUE!=0: VALUE decrements by 1.
  - VALUE==0: TOF<=1.
    - Periodic (ONESHOT=0): VALUE<=LOAD.
    - One-shot: EN<=0 and VALUE stays 0.
  - Period is (LOAD+1)*(PSC+1) cycles. LOAD=0 in periodic mode sets TOF every tick.
- Timer stop: EN=0 freezes VALUE; no ticks occur.
- timer_irq: registered, equals TOF & IE one cycle later. Clearing IE deasserts it without clearing TOF.
- Simultaneous events:
  - Bus write to VALUE in the same cycle as a tick: the write wins and no decrement occurs.
  - CTRL write clearing EN in the same cycle as a tick: the write wins and no decrement or TOF set occurs.
  - STATUS clear in the same cycle as a hardware TOF set: the set wins (TOF=1).
  - One-shot expiry in the same cycle as a CTRL write setting EN=1: the write wins and reload occurs.
- Reset mid-count: all state returns immediately (asynchronously) to the reset values.
- LOAD written while running takes effect at the next reload only.

Optional Feature:
- AHB_TIMER_PWM_EN defined:
  - Adds the COMPARE register at 0x10 (WIDTH bits, reset 0).
  - pwm_out is registered: (EN & (VALUE < COMPARE)) one cycle late.
  - COMPARE=0 gives constant 0.
  - COMPARE>LOAD gives constant 1 while enabled.
- Not defined: 0x10 reads 0 and ignores writes; pwm_out is tied to 0; no COMPARE flops are synthesised.

Test Plan:
- Reset: assert HRESETn=0 mid-count -> all registers read 0, timer_irq=0, HREADYOUT=1 throughout.
- Periodic: LOAD=4, CTRL=0x0000_0003 (PSC=0, EN, IE) -> TOF set and timer_irq high 1 cycle later, every 5 cycles; VALUE reads 4,3,2,1,0,4.
- Prescale/one-shot: LOAD=2, CTRL=0x0000_0305 (PSC=3) -> TOF set at cycle 12 after the enable write, then EN reads 0 and VALUE stays 0.
- TOF clear race: write STATUS=1 in the exact cycle of a timeout -> TOF remains 1. Then write STATUS=1 alone -> TOF=0 and timer_irq=0 the next cycle.
- Bus priority: write VALUE=0x100 on a tick cycle -> VALUE reads 0x100, not 0xFF. A back-to-back write then read of LOAD returns the new value with zero wait states.
- PWM (macro on): LOAD=9, COMPARE=3, PSC=0, EN -> pwm_out high for 3 of every 10 cycles. Macro off -> 0x10 reads 0 and pwm_out stays 0.
